frac_div_ctrl: RTL and testbench

- Sequencing/configuration controller for the half-integer clock divider. Owns the divider's run enable and its MUL_2 ratio (twice the division ratio).
- Accepts ratio changes through a valid/ready handshake and enable/disable requests as a level.
- Commits every change only at a divided-period boundary, so the divider never sees a ratio change mid-period.
- Keeps a phase counter that mirrors the divider's count (0..MUL_2-1), used for alignment and status.

---
 rtl/frac_div_pkg.sv | 24 ++
 rtl/frac_div_phase_cnt.sv | 29 ++
 rtl/frac_div_ctrl.sv | 125 ++++++++++++
 tb/tb_frac_div_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_div_pkg.sv
// Shared definitions for the half-integer clock divider controller:
// state encoding, default ratio limits and the MUL_2 range check.
package frac_div_pkg;

   localparam int unsigned CNT_W_DEF    = 5;
   localparam int unsigned MUL2_MIN_DEF = 3;   // ratio 1.5
   localparam int unsigned MUL2_MAX_DEF = 31;  // must fit in CNT_W bits
   localparam int unsigned MUL2_RST_DEF = 9;   // ratio 4.5

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // True when v lies within [lo, hi].
   function automatic logic is_legal_mul2(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/frac_div_phase_cnt.sv
// Modulo-mod_i phase counter that mirrors the divider's internal count.
// Clears to 0 on clr_i, counts 0..mod_i-1 while en_i is high.
module frac_div_phase_cnt #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] mod_i,
   output logic [CNT_W-1:0] phase_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] phase_q;

   assign wrap_o  = (phase_q == (mod_i - CNT_W'(1)));
   assign phase_o = phase_q;

   // Phase register: clear, or advance and fold back to 0 on wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         phase_q <= '0;
      end else if (en_i) begin
         phase_q <= wrap_o ? '0 : phase_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/frac_div_ctrl.sv
// Sequencing/configuration controller for the half-integer clock divider.
// Owns the run enable and the active MUL_2 ratio; ratio changes and
// disables are only committed at a divided-period boundary (wrap).
module frac_div_ctrl #(
   parameter int unsigned CNT_W    = frac_div_pkg::CNT_W_DEF,
   parameter int unsigned MUL2_MIN = frac_div_pkg::MUL2_MIN_DEF,
   parameter int unsigned MUL2_MAX = frac_div_pkg::MUL2_MAX_DEF,
   parameter int unsigned MUL2_RST = frac_div_pkg::MUL2_RST_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_req,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_mul2,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_run,
   output logic             div_load,
   output logic [CNT_W-1:0] div_mul2,
   output logic [CNT_W-1:0] phase,
   output logic             wrap,
   output logic [1:0]       state_o
);

   import frac_div_pkg::*;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] mul2_q, mul2_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             load_q, load_d;
   logic             err_q, err_d;

   logic             idle;
   logic             ready;
   logic             hs;
   logic             legal;
   logic             cnt_wrap;
   logic             wrap_w;
   logic [CNT_W-1:0] phase_w;

   assign idle  = (state_q == ST_IDLE);
   assign ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign hs    = cfg_valid & ready;
   assign legal = is_legal_mul2(32'(cfg_mul2), MUL2_MIN, MUL2_MAX);
   // The raw decode is meaningless while the counter is parked in IDLE.
   assign wrap_w = cnt_wrap & ~idle;

   frac_div_phase_cnt #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (idle),
      .en_i    (~idle),
      .mod_i   (mul2_q),
      .phase_o (phase_w),
      .wrap_o  (cnt_wrap)
   );

   // Next-state and config-register update rules.
   always_comb begin
      state_d = state_q;
      mul2_d  = mul2_q;
      pend_d  = pend_q;
      load_d  = 1'b0;
      err_d   = hs & ~legal;
      unique case (state_q)
         ST_IDLE: begin
            if (hs && legal) begin
               mul2_d = cfg_mul2;
               load_d = 1'b1;
            end
            if (en_req) state_d = ST_RUN;
         end
         ST_RUN: begin
            // A legal offer beats a disable; en_req is re-examined at the wrap.
            if (hs && legal) begin
               pend_d  = cfg_mul2;
               state_d = ST_PEND;
            end else if (!en_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_PEND: begin
            if (wrap_w) begin
               mul2_d  = pend_q;
               load_d  = 1'b1;
               state_d = en_req ? ST_RUN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (en_req)      state_d = ST_RUN;
            else if (wrap_w) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, active ratio, pending ratio and the one-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mul2_q  <= CNT_W'(MUL2_RST);
         pend_q  <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mul2_q  <= mul2_d;
         pend_q  <= pend_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   assign cfg_ready = ready;
   assign cfg_err   = err_q;
   assign div_run   = ~idle;
   assign div_load  = load_q;
   assign div_mul2  = mul2_q;
   assign phase     = phase_w;
   assign wrap      = wrap_w;
   assign state_o   = state_q;

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Bench for frac_div_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model described in terms of running / pending / draining flags.
module tb_frac_div_ctrl;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_req;
   logic          cfg_valid;
   logic [CW-1:0] cfg_mul2;
   logic          cfg_ready, cfg_err, div_run, div_load, wrap;
   logic [CW-1:0] div_mul2, phase;
   logic [1:0]    state_o;

   int tests_run = 0;
   int tests_failed = 0;
   bit cmp_en = 1'b0;

   frac_div_ctrl #(
      .CNT_W    (CW),
      .MUL2_MIN (3),
      .MUL2_MAX (31),
      .MUL2_RST (9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en_req    (en_req),
      .cfg_valid (cfg_valid),
      .cfg_mul2  (cfg_mul2),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .div_run   (div_run),
      .div_load  (div_load),
      .div_mul2  (div_mul2),
      .phase     (phase),
      .wrap      (wrap),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit run;       // divider enabled
      bit has_pend;  // a ratio is waiting for the next boundary
      bit drain;     // disable requested, finishing the current period
      bit err;
      bit load;
      int mul2;
      int phase;
      int pend;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.run = 0; r.has_pend = 0; r.drain = 0; r.err = 0; r.load = 0;
      r.mul2 = 9; r.phase = 0; r.pend = 0;
      return r;
   endfunction

   function automatic bit m_ready(model_t c);
      return !c.run || (!c.has_pend && !c.drain);
   endfunction

   function automatic bit m_wrap(model_t c);
      return c.run && (c.phase == c.mul2 - 1);
   endfunction

   function automatic int m_state(model_t c);
      if (!c.run)     return 0;
      if (c.has_pend) return 2;
      if (c.drain)    return 3;
      return 1;
   endfunction

   function automatic model_t next_model(model_t c, bit en, bit vld, int v);
      model_t n = c;
      bit hs    = vld && m_ready(c);
      bit legal = (v >= 3) && (v <= 31);
      bit wr    = m_wrap(c);
      n.err  = hs && !legal;
      n.load = 0;
      if (!c.run) begin
         n.phase = 0;
         if (hs && legal) begin n.mul2 = v; n.load = 1; end
         if (en) n.run = 1;
      end else begin
         n.phase = wr ? 0 : c.phase + 1;
         if (c.has_pend) begin
            if (wr) begin
               n.mul2 = c.pend; n.load = 1; n.has_pend = 0; n.run = en;
            end
         end else if (c.drain) begin
            if (en) n.drain = 0;
            else if (wr) begin n.run = 0; n.drain = 0; end
         end else if (hs && legal) begin
            n.has_pend = 1; n.pend = v;
         end else if (!en) begin
            n.drain = 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) m <= model_reset();
      else     m <= next_model(m, en_req, cfg_valid, int'(cfg_mul2));
   end

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("state_o",   int'(state_o),   m_state(m));
         check("div_run",   int'(div_run),   int'(m.run));
         check("cfg_ready", int'(cfg_ready), int'(m_ready(m)));
         check("div_mul2",  int'(div_mul2),  m.mul2);
         check("phase",     int'(phase),     m.phase);
         check("wrap",      int'(wrap),      int'(m_wrap(m)));
         check("div_load",  int'(div_load),  int'(m.load));
         check("cfg_err",   int'(cfg_err),   int'(m.err));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; en_req = 1'b0; cfg_valid = 1'b0; cfg_mul2 = '0;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      cyc(1);
      check("rst_mul2", int'(div_mul2), 9);
      check("rst_run", int'(div_run), 0);
      check("rst_ready", int'(cfg_ready), 1);
      check("rst_phase", int'(phase), 0);
      check("rst_state", int'(state_o), 0);

      // Enable and run one full period at MUL_2 = 9.
      rst = 1'b0; en_req = 1'b1;
      cyc(1);
      check("en_run", int'(div_run), 1);
      check("en_phase0", int'(phase), 0);
      cyc(8);
      check("p8_phase", int'(phase), 8);
      check("p8_wrap", int'(wrap), 1);
      cyc(1);
      check("p8_back0", int'(phase), 0);

      // Ratio change to 7 offered at phase 2.
      cyc(2);
      cfg_valid = 1'b1; cfg_mul2 = 5'd7;
      cyc(1);
      cfg_valid = 1'b0;
      check("pend_state", int'(state_o), 2);
      check("pend_ready", int'(cfg_ready), 0);
      check("pend_mul2_old", int'(div_mul2), 9);
      cyc(5);
      check("pend_wrap_mul2", int'(div_mul2), 9);
      check("pend_wrap", int'(wrap), 1);
      cyc(1);
      check("chg_load", int'(div_load), 1);
      check("chg_mul2", int'(div_mul2), 7);
      check("chg_phase", int'(phase), 0);
      cyc(6);
      check("m7_wrap_phase", int'(phase), 6);
      check("m7_wrap", int'(wrap), 1);

      // Drain: drop en_req at phase 3 (MUL_2 back to 9 via reset).
      rst = 1'b1; cyc(1); rst = 1'b0;
      cyc(1);
      check("drn_start", int'(phase), 0);
      cyc(3);
      en_req = 1'b0;
      cyc(1);
      check("drn_state", int'(state_o), 3);
      check("drn_phase", int'(phase), 4);
      cyc(4);
      check("drn_wrap", int'(wrap), 1);
      cyc(1);
      check("drn_idle", int'(state_o), 0);
      check("drn_run", int'(div_run), 0);
      check("drn_phase0", int'(phase), 0);

      // Drain aborted by re-raising en_req at phase 5.
      en_req = 1'b1;
      cyc(4);
      en_req = 1'b0;
      cyc(2);
      check("abort_phase5", int'(phase), 5);
      en_req = 1'b1;
      cyc(1);
      check("abort_state", int'(state_o), 1);
      check("abort_phase6", int'(phase), 6);
      cyc(3);
      check("abort_phase0", int'(phase), 0);

      // Illegal offers in IDLE.
      en_req = 1'b0;
      cyc(9);
      check("ill_idle", int'(state_o), 0);
      cfg_valid = 1'b1; cfg_mul2 = 5'd2;
      cyc(1);
      check("ill2_err", int'(cfg_err), 1);
      check("ill2_load", int'(div_load), 0);
      cfg_mul2 = 5'd0;
      cyc(1);
      check("ill0_err", int'(cfg_err), 1);
      cfg_valid = 1'b0;
      cyc(1);
      check("ill_err_clr", int'(cfg_err), 0);
      check("ill_mul2", int'(div_mul2), 9);

      // Enable together with a legal offer of 5.
      en_req = 1'b1; cfg_valid = 1'b1; cfg_mul2 = 5'd5;
      cyc(1);
      cfg_valid = 1'b0;
      check("sim_load", int'(div_load), 1);
      check("sim_run", int'(div_run), 1);
      check("sim_mul2", int'(div_mul2), 5);
      cyc(4);
      check("sim_wrap4", int'(wrap), 1);
      cyc(1);

      // In PEND, drop en_req before the wrap: load then straight to IDLE.
      cfg_valid = 1'b1; cfg_mul2 = 5'd3;
      cyc(1);
      cfg_valid = 1'b0;
      check("pi_state", int'(state_o), 2);
      en_req = 1'b0;
      cyc(3);
      check("pi_wrap", int'(wrap), 1);
      cyc(1);
      check("pi_idle", int'(state_o), 0);
      check("pi_load", int'(div_load), 1);
      check("pi_mul2", int'(div_mul2), 3);

      // Reset while PEND at phase 4: pending value is discarded.
      rst = 1'b1; cyc(1); rst = 1'b0;
      en_req = 1'b1;
      cyc(1);
      cfg_valid = 1'b1; cfg_mul2 = 5'd12;
      cyc(1);
      cfg_valid = 1'b0;
      cyc(3);
      check("rmid_phase4", int'(phase), 4);
      check("rmid_pend", int'(state_o), 2);
      rst = 1'b1;
      cyc(1);
      check("rmid_state", int'(state_o), 0);
      check("rmid_mul2", int'(div_mul2), 9);
      check("rmid_phase", int'(phase), 0);
      check("rmid_run", int'(div_run), 0);
      rst = 1'b0; en_req = 1'b0;
      cyc(12);
      check("rmid_noload", int'(div_mul2), 9);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) en_req = ~en_req;
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_mul2  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 31))
                                                 : CW'($urandom_range(3, 12));
         cyc(1);
      end
      rst = 1'b0; cfg_valid = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
